// File: rtl/tx_pwm_pkg.sv
// rtl/tx_pwm_pkg.sv - shared types and duty codes for the TX PWM sequencer
package tx_pwm_pkg;

    typedef logic [3:0] code_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_GAP
    } state_t;

    localparam code_t IDLE_CODE = 4'd8;
    localparam code_t PRE_HI    = 4'd15;
    localparam code_t PRE_LO    = 4'd0;

endpackage

// File: rtl/tx_pwm_symtimer.sv
// rtl/tx_pwm_symtimer.sv - symbol-period divider producing the symbol strobe
module tx_pwm_symtimer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sym_stb
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    logic [CW-1:0] r_divcnt;

    // divcnt runs 0..DIV-1 while enabled and parks at 0 when disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_divcnt <= '0;
        end else if (!en) begin
            r_divcnt <= '0;
        end else if (r_divcnt == DIV_LAST) begin
            r_divcnt <= '0;
        end else begin
            r_divcnt <= r_divcnt + CW'(1);
        end
    end

    assign sym_stb = en && (r_divcnt == DIV_LAST);

endmodule

// File: rtl/tx_pwm_sequencer.sv
// rtl/tx_pwm_sequencer.sv - frame sequencer emitting idle/preamble/data/gap duty codes
module tx_pwm_sequencer
    import tx_pwm_pkg::*;
#(
    parameter int DIV  = 4,
    parameter int NPRE = 8,
    parameter int NGAP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic [3:0]  sym_code,
    output logic        sym_stb,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun
);

    localparam int PW = $clog2(NPRE);
    localparam int GW = $clog2(NGAP + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(NPRE - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(NGAP - 1);

    state_t         r_state;
    logic [PW-1:0]  r_precnt;
    logic [1:0]     r_nib;
    logic [GW-1:0]  r_gapcnt;
    logic [15:0]    r_shreg;
    logic           r_last_q;
    code_t          r_sym_code;
    logic           r_frame_done;
    logic           r_underrun;

    state_t         w_state;
    logic [PW-1:0]  w_precnt;
    logic [1:0]     w_nib;
    logic [GW-1:0]  w_gapcnt;
    logic [15:0]    w_shreg;
    logic           w_last_q;
    code_t          w_code;
    logic           w_ready;
    logic           w_frame_done;
    logic           w_underrun;
    logic           w_stb;

    tx_pwm_symtimer #(
        .DIV (DIV)
    ) u_symtimer (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .sym_stb (w_stb)
    );

    // next-state, counter and handshake decisions, taken only on a symbol strobe
    always_comb begin
        w_state      = r_state;
        w_precnt     = r_precnt;
        w_nib        = r_nib;
        w_gapcnt     = r_gapcnt;
        w_shreg      = r_shreg;
        w_last_q     = r_last_q;
        w_ready      = 1'b0;
        w_frame_done = 1'b0;
        w_underrun   = 1'b0;

        if (!en) begin
            w_state  = S_IDLE;
            w_precnt = '0;
            w_nib    = '0;
            w_gapcnt = '0;
            w_shreg  = '0;
            w_last_q = 1'b0;
        end else if (w_stb) begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        w_state  = S_PRE;
                        w_precnt = '0;
                    end
                end
                S_PRE: begin
                    if (r_precnt == PRE_LAST) begin
                        w_ready = 1'b1;
                        if (in_valid) begin
                            w_shreg  = in_data;
                            w_last_q = in_last;
                            w_nib    = '0;
                            w_state  = S_DATA;
                        end else begin
                            w_underrun = 1'b1;
                            w_gapcnt   = '0;
                            w_state    = S_GAP;
                        end
                    end else begin
                        w_precnt = r_precnt + PW'(1);
                    end
                end
                S_DATA: begin
                    if (r_nib == 2'd3) begin
                        if (r_last_q) begin
                            w_frame_done = 1'b1;
                            w_gapcnt     = '0;
                            w_state      = S_GAP;
                        end else begin
                            w_ready = 1'b1;
                            if (in_valid) begin
                                w_shreg  = in_data;
                                w_last_q = in_last;
                                w_nib    = '0;
                            end else begin
                                w_underrun = 1'b1;
                                w_gapcnt   = '0;
                                w_state    = S_GAP;
                            end
                        end
                    end else begin
                        w_shreg = {r_shreg[11:0], 4'h0};
                        w_nib   = r_nib + 2'd1;
                    end
                end
                S_GAP: begin
                    if (r_gapcnt == GAP_LAST) begin
                        w_gapcnt = '0;
                        w_state  = S_IDLE;
                    end else begin
                        w_gapcnt = r_gapcnt + GW'(1);
                    end
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    // duty code for the upcoming symbol, derived from the next state
    always_comb begin
        w_code = IDLE_CODE;
        case (w_state)
            S_PRE:   w_code = w_precnt[0] ? PRE_LO : PRE_HI;
            S_DATA:  w_code = w_shreg[15:12];
            default: w_code = IDLE_CODE;
        endcase
    end

    // state register; the code only moves when the next state does
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_precnt     <= '0;
            r_nib        <= '0;
            r_gapcnt     <= '0;
            r_shreg      <= '0;
            r_last_q     <= 1'b0;
            r_sym_code   <= IDLE_CODE;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_precnt     <= w_precnt;
            r_nib        <= w_nib;
            r_gapcnt     <= w_gapcnt;
            r_shreg      <= w_shreg;
            r_last_q     <= w_last_q;
            r_sym_code   <= w_code;
            r_frame_done <= w_frame_done;
            r_underrun   <= w_underrun;
        end
    end

    assign in_ready   = w_ready;
    assign sym_code   = r_sym_code;
    assign sym_stb    = w_stb;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;
    assign underrun   = r_underrun;

endmodule
